// File: rtl/c_module_pkg.sv
// Shared widths, slot state encoding and slot record for the lookup responder.
package c_module_pkg;

  localparam int LKP_INFO_W = 32;
  localparam int REQ_ID_W   = 6;
  localparam int RSLT_W     = 16;
  localparam int LAT_CNT_W  = 5;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_e;

  // The result is folded at acceptance, so a slot never needs the full key.
  typedef struct packed {
    slot_state_e          state;
    logic [REQ_ID_W-1:0]  req_id;
    logic [RSLT_W-1:0]    rslt;
    logic [LAT_CNT_W-1:0] cnt;
  } slot_t;

  function automatic logic [RSLT_W-1:0] calc_rslt(input logic [LKP_INFO_W-1:0] info);
    return info[31:16] ^ info[15:0];
  endfunction

endpackage

// File: rtl/a_lkp_rsp_arb.sv
// Fixed-priority picker: reports the lowest set index of a request vector.
module a_lkp_rsp_arb #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/a_lkp_responder.sv
// Slot-based lookup responder: requests wait a latency, then retire lowest slot first.
// Define A_LKP_VAR_LAT_EN to extend each request's latency by info[1:0].
module a_lkp_responder
  import c_module_pkg::*;
#(
  parameter int SLOT_NUM = 8,
  parameter int BASE_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c2a_lkp_vld,
  input  logic [LKP_INFO_W-1:0] c2a_lkp_info,
  input  logic [REQ_ID_W-1:0]   c2a_lkp_req_id,
  output logic                  a2c_lkp_rdy,
  output logic                  a2c_lkp_rsp_vld,
  output logic [REQ_ID_W-1:0]   a2c_lkp_rsp_id,
  output logic [RSLT_W-1:0]     a2c_lkp_rslt
);

  localparam int IDX_W = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
  localparam logic [LAT_CNT_W-1:0] BASE_LAT_M1 = LAT_CNT_W'(BASE_LAT - 1);

  slot_t                slots     [SLOT_NUM];
  slot_t                slots_nxt [SLOT_NUM];
  logic [SLOT_NUM-1:0]  ready_vec;
  logic [SLOT_NUM-1:0]  idle_vec;
  logic [IDX_W-1:0]     rsp_idx;
  logic [IDX_W-1:0]     free_idx;
  logic                 rsp_any;
  logic                 free_any;
  logic                 accept;
  logic                 rdy_nxt;
  logic [LAT_CNT_W-1:0] acc_cnt;

  // A WAIT slot whose counter hit zero competes now, so its response lands at edge k+LAT.
  always_comb begin
    ready_vec = '0;
    idle_vec  = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      ready_vec[i] = (slots[i].state == SLOT_READY) ||
                     ((slots[i].state == SLOT_WAIT) && (slots[i].cnt == '0));
      idle_vec[i]  = (slots[i].state == SLOT_IDLE);
    end
  end

  a_lkp_rsp_arb #(.N(SLOT_NUM)) u_rsp_arb (
    .req (ready_vec),
    .idx (rsp_idx),
    .any (rsp_any)
  );

  a_lkp_rsp_arb #(.N(SLOT_NUM)) u_free_arb (
    .req (idle_vec),
    .idx (free_idx),
    .any (free_any)
  );

  assign accept = c2a_lkp_vld && a2c_lkp_rdy && free_any;

`ifdef A_LKP_VAR_LAT_EN
  assign acc_cnt = BASE_LAT_M1 + LAT_CNT_W'(c2a_lkp_info[1:0]);
`else
  assign acc_cnt = BASE_LAT_M1;
`endif

  // A slot retiring this edge is not counted as free until the following edge.
  always_comb begin
    rdy_nxt = 1'b0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      slots_nxt[i] = slots[i];
      if (slots[i].state == SLOT_WAIT) begin
        if (slots[i].cnt == '0) slots_nxt[i].state = SLOT_READY;
        else                    slots_nxt[i].cnt   = slots[i].cnt - 1'b1;
      end
      if (rsp_any && (rsp_idx == IDX_W'(i))) begin
        slots_nxt[i] = '0;
      end
      if (accept && (free_idx == IDX_W'(i))) begin
        slots_nxt[i].state  = SLOT_WAIT;
        slots_nxt[i].req_id = c2a_lkp_req_id;
        slots_nxt[i].rslt   = calc_rslt(c2a_lkp_info);
        slots_nxt[i].cnt    = acc_cnt;
      end
      if ((slots_nxt[i].state == SLOT_IDLE) && !(rsp_any && (rsp_idx == IDX_W'(i)))) begin
        rdy_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOT_NUM; i++) slots[i] <= '0;
      a2c_lkp_rdy     <= 1'b0;
      a2c_lkp_rsp_vld <= 1'b0;
      a2c_lkp_rsp_id  <= '0;
      a2c_lkp_rslt    <= '0;
    end else begin
      for (int i = 0; i < SLOT_NUM; i++) slots[i] <= slots_nxt[i];
      a2c_lkp_rdy     <= rdy_nxt;
      a2c_lkp_rsp_vld <= rsp_any;
      a2c_lkp_rsp_id  <= rsp_any ? slots[rsp_idx].req_id : '0;
      a2c_lkp_rslt    <= rsp_any ? slots[rsp_idx].rslt   : '0;
    end
  end

endmodule
